// File: rtl/y_tap_window_pkg.sv
// Shared constants and encodings for the vertical tap window generator.
package y_tap_window_pkg;

  // Sample width: 8.7 fixed point.
  localparam int TW_DW    = 15;
  // Default number of output phases per window.
  localparam int TW_SCALE = 4;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL1 = 3'd1,
    ST_FILL2 = 3'd2,
    ST_EMIT  = 3'd3,
    ST_WAIT  = 3'd4
  } tw_state_e;

  // Operations on the four-entry tap register.
  typedef enum logic [2:0] {
    OP_HOLD      = 3'd0,
    OP_LOAD_ALL  = 3'd1,  // t0..t3 <= x
    OP_LOAD_23   = 3'd2,  // t2,t3 <= x
    OP_LOAD_3    = 3'd3,  // t3 <= x
    OP_SHIFT_IN  = 3'd4,  // shift down, t3 <= x
    OP_SHIFT_REP = 3'd5   // shift down, t3 held (bottom edge clamp)
  } tap_op_e;

endpackage

// File: rtl/y_tap_shift4.sv
// Four-entry tap register: load-all, partial-load, shift and replicate-shift.
module y_tap_shift4
  import y_tap_window_pkg::*;
#(
  parameter int DW = TW_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  tap_op_e       op_i,
  input  logic [DW-1:0] x_i,
  output logic [DW-1:0] t0_o,
  output logic [DW-1:0] t1_o,
  output logic [DW-1:0] t2_o,
  output logic [DW-1:0] t3_o
);

  logic [DW-1:0] t0_q, t1_q, t2_q, t3_q;
  logic [DW-1:0] t0_d, t1_d, t2_d, t3_d;

  // Next tap contents selected by the requested operation.
  always_comb begin
    t0_d = t0_q;
    t1_d = t1_q;
    t2_d = t2_q;
    t3_d = t3_q;
    case (op_i)
      OP_LOAD_ALL: begin
        t0_d = x_i; t1_d = x_i; t2_d = x_i; t3_d = x_i;
      end
      OP_LOAD_23: begin
        t2_d = x_i; t3_d = x_i;
      end
      OP_LOAD_3: t3_d = x_i;
      OP_SHIFT_IN: begin
        t0_d = t1_q; t1_d = t2_q; t2_d = t3_q; t3_d = x_i;
      end
      OP_SHIFT_REP: begin
        t0_d = t1_q; t1_d = t2_q; t2_d = t3_q;
      end
      default: ;
    endcase
  end

  // Tap registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t0_q <= '0; t1_q <= '0; t2_q <= '0; t3_q <= '0;
    end else begin
      t0_q <= t0_d; t1_q <= t1_d; t2_q <= t2_d; t3_q <= t3_d;
    end
  end

  assign t0_o = t0_q;
  assign t1_o = t1_q;
  assign t2_o = t2_q;
  assign t3_o = t3_q;

endmodule

// File: rtl/y_tap_window.sv
// Vertical 4-tap window generator with edge clamping. Each window
// p[k-1..k+2] is presented SCALE times, once per weight-table phase.
// Handshakes: a beat moves on a channel in every cycle where its valid and
// ready are both high at the rising edge; valid never depends on ready,
// while s_ready may depend on m_ready (same-cycle refill at the last phase).
module y_tap_window
  import y_tap_window_pkg::*;
#(
  parameter int DW    = TW_DW,
  parameter int SCALE = TW_SCALE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DW-1:0]            out_0,
  output logic [DW-1:0]            out_1,
  output logic [DW-1:0]            out_2,
  output logic [DW-1:0]            out_3,
  output logic [$clog2(SCALE)-1:0] m_phase,
  output logic                     m_last,
  output tw_state_e                dbg_state_o
);

  localparam int PW = $clog2(SCALE);
  localparam logic [PW-1:0] PH_MAX = PW'(SCALE - 1);

  tw_state_e     state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    tail_q, tail_d;   // clamp windows still owed after s_last
  logic          last_q, last_d;   // s_last of this column has been accepted
  tap_op_e       op;
  logic          m_hs, at_end, take_c, s_acc;

  // Next-state, tap operation and handshake decode.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tail_d  = tail_q;
    last_d  = last_q;
    op      = OP_HOLD;
    m_hs    = (state_q == ST_EMIT) && m_ready;
    at_end  = m_hs && (phase_q == PH_MAX);
    take_c  = at_end && (tail_q == 2'd0) && !last_q;
    s_ready = (state_q != ST_EMIT) || take_c;
    s_acc   = s_valid && s_ready;
    case (state_q)
      ST_IDLE: if (s_acc) begin
        op      = OP_LOAD_ALL;
        phase_d = '0;
        tail_d  = 2'd0;
        last_d  = s_last;
        state_d = s_last ? ST_EMIT : ST_FILL1;
      end
      ST_FILL1: if (s_acc) begin
        op = OP_LOAD_23;
        if (s_last) begin
          state_d = ST_EMIT; tail_d = 2'd1; last_d = 1'b1;
        end else begin
          state_d = ST_FILL2;
        end
      end
      ST_FILL2: if (s_acc) begin
        op      = OP_LOAD_3;
        state_d = ST_EMIT;
        if (s_last) begin
          tail_d = 2'd2; last_d = 1'b1;
        end
      end
      ST_EMIT: if (m_hs) begin
        if (phase_q != PH_MAX) begin
          phase_d = phase_q + 1'b1;
        end else if (tail_q != 2'd0) begin
          op = OP_SHIFT_REP; tail_d = tail_q - 2'd1; phase_d = '0;
        end else if (last_q) begin
          state_d = ST_IDLE; last_d = 1'b0; phase_d = '0;
        end else if (s_valid) begin
          op = OP_SHIFT_IN; phase_d = '0;
          if (s_last) begin
            tail_d = 2'd2; last_d = 1'b1;
          end
        end else begin
          state_d = ST_WAIT; phase_d = '0;
        end
      end
      ST_WAIT: if (s_acc) begin
        op = OP_SHIFT_IN; state_d = ST_EMIT; phase_d = '0;
        if (s_last) begin
          tail_d = 2'd2; last_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      tail_q  <= 2'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tail_q  <= tail_d;
      last_q  <= last_d;
    end
  end

  y_tap_shift4 #(.DW(DW)) u_taps (
    .clk  (clk),
    .rst  (rst),
    .op_i (op),
    .x_i  (s_data),
    .t0_o (out_0),
    .t1_o (out_1),
    .t2_o (out_2),
    .t3_o (out_3)
  );

  assign m_valid     = (state_q == ST_EMIT);
  assign m_phase     = phase_q;
  assign m_last      = (state_q == ST_EMIT) && last_q && (tail_q == 2'd0) && (phase_q == PH_MAX);
  assign dbg_state_o = state_q;

endmodule
